// File: rtl/rs_pkg.sv
// Shared types, default field polynomial and constant GF(2^M) helpers
// for the Reed-Solomon syndrome engine.
package rs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } rs_state_t;

  localparam int GF_MAX_W = 16;
  localparam logic [3:0] RS_PRIM_POLY = 4'b1011;

  // a * alpha^pow in GF(2^m), alpha = x; evaluated at elaboration time only.
  function automatic logic [GF_MAX_W-1:0] gf_mul_alpha_pow(
    input logic [GF_MAX_W-1:0] a,
    input int                  m,
    input logic [GF_MAX_W:0]   poly,
    input int                  pow
  );
    logic [GF_MAX_W:0] acc;
    acc = {1'b0, a};
    for (int p = 0; p < pow; p++) begin
      acc = acc << 1;
      if (acc[m]) acc = acc ^ poly;
    end
    return acc[GF_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Multiply a GF(2^M) element by the constant alpha^POW as a fixed XOR network
// built from the images of the basis vectors.
module gf_const_mul
  import rs_pkg::*;
#(
  parameter int           M         = 3,
  parameter logic [M:0]   PRIM_POLY = (M+1)'(RS_PRIM_POLY),
  parameter int           POW       = 1
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);

  logic [M-1:0] col [M];

  for (genvar i = 0; i < M; i++) begin : g_col
    localparam logic [GF_MAX_W-1:0] COL_W =
      gf_mul_alpha_pow(GF_MAX_W'(1) << i, M, (GF_MAX_W+1)'(PRIM_POLY), POW);
    assign col[i] = COL_W[M-1:0];
  end

  always_comb begin
    y = '0;
    for (int i = 0; i < M; i++) begin
      if (a[i]) y = y ^ col[i];
    end
  end

endmodule

// File: rtl/rs_syndrome_engine.sv
// Streaming Reed-Solomon syndrome calculator: Horner evaluation of the
// received polynomial at alpha^1..alpha^NSYN with a one-deep result hold.
module rs_syndrome_engine
  import rs_pkg::*;
#(
  parameter int         M         = 3,
  parameter int         N         = 7,
  parameter int         NSYN      = 2,
  parameter logic [M:0] PRIM_POLY = (M+1)'(RS_PRIM_POLY)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M-1:0]      in_sym,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NSYN*M-1:0] syn,
  output logic              err_flag,
  output logic              len_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  rs_state_t     state;
  logic [CW-1:0] cnt;
  logic [M-1:0]  acc     [1:NSYN];
  logic [M-1:0]  prod    [1:NSYN];
  logic [M-1:0]  acc_nxt [1:NSYN];
  logic          accept;
  logic          term;
  logic          len_bad;
  logic          any_nz;

  for (genvar j = 1; j <= NSYN; j++) begin : g_syn
    gf_const_mul #(
      .M         (M),
      .PRIM_POLY (PRIM_POLY),
      .POW       (j)
    ) u_mul (
      .a (acc[j]),
      .y (prod[j])
    );
    assign syn[j*M-1 -: M] = acc[j];
  end

  assign accept  = in_valid & in_ready;
  assign term    = in_last | (cnt == CW'(N-1));
  assign len_bad = in_last ? (cnt != CW'(N-1)) : 1'b1;

  // The first symbol of a codeword starts from an implicit zero accumulator.
  always_comb begin
    any_nz = 1'b0;
    for (int j = 1; j <= NSYN; j++) begin
      acc_nxt[j] = ((state == ST_ACCUM) ? prod[j] : '0) ^ in_sym;
      any_nz     = any_nz | (|acc_nxt[j]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      err_flag  <= 1'b0;
      len_err   <= 1'b0;
      for (int j = 1; j <= NSYN; j++) acc[j] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            for (int j = 1; j <= NSYN; j++) acc[j] <= acc_nxt[j];
            if (term) begin
              state     <= ST_HOLD;
              cnt       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              err_flag  <= any_nz;
              len_err   <= len_bad;
            end else begin
              state <= ST_ACCUM;
              cnt   <= cnt + CW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_syndrome_engine.sv
// Directed bench for rs_syndrome_engine at M=3, N=7, NSYN=2 (x^3+x+1).
module tb_rs_syndrome_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_sym;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] syn;
  logic       err_flag;
  logic       len_err;

  int checks   = 0;
  int failures = 0;

  rs_syndrome_engine #(.M(3), .N(7), .NSYN(2), .PRIM_POLY(4'b1011)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .syn       (syn),
    .err_flag  (err_flag),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [2:0] s, input logic l);
    in_valid = 1'b1;
    in_sym   = s;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_sym   = 3'b000;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (syn !== 6'b0) begin failures++; $display("FAIL reset_syn: got %b expected 000000", syn); end
    checks++; if (err_flag !== 1'b0 || len_err !== 1'b0) begin failures++; $display("FAIL reset_flags: got err=%b len=%b expected 0 0", err_flag, len_err); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_zero_codeword();
    for (int i = 0; i < 6; i++) send(3'b000, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL zero_early_valid: got %b expected 0", out_valid); end
    send(3'b000, 1'b1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL zero_latency: got %b expected 1", out_valid); end
    checks++; if (syn !== 6'b000000) begin failures++; $display("FAIL zero_syn: got %b expected 000000", syn); end
    checks++; if (err_flag !== 1'b0 || len_err !== 1'b0) begin failures++; $display("FAIL zero_flags: got err=%b len=%b expected 0 0", err_flag, len_err); end
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL zero_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready); end
  endtask

  task automatic test_generator();
    logic [2:0] w [7];
    w = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b110, 3'b011};
    for (int i = 0; i < 7; i++) send(w[i], i == 6);
    checks++; if (out_valid !== 1'b1 || syn !== 6'b000000) begin failures++; $display("FAIL gen_syn: got valid=%b syn=%b expected 1 000000", out_valid, syn); end
    checks++; if (err_flag !== 1'b0 || len_err !== 1'b0) begin failures++; $display("FAIL gen_flags: got err=%b len=%b expected 0 0", err_flag, len_err); end
    consume();
  endtask

  task automatic test_leading_one();
    send(3'b001, 1'b0);
    for (int i = 0; i < 5; i++) send(3'b000, 1'b0);
    send(3'b000, 1'b1);
    checks++; if (syn !== 6'b111101) begin failures++; $display("FAIL lead_syn: got %b expected 111101", syn); end
    checks++; if (err_flag !== 1'b1 || len_err !== 1'b0) begin failures++; $display("FAIL lead_flags: got err=%b len=%b expected 1 0", err_flag, len_err); end
    consume();
  endtask

  task automatic test_gaps_and_hold();
    int bad_hold;
    for (int i = 0; i < 6; i++) begin
      send(3'b000, 1'b0);
      in_valid = 1'b0; in_last = 1'b1; in_sym = 3'b111;
      repeat (i % 3) @(posedge clk);
      #1;
      in_last = 1'b0; in_sym = 3'b000;
    end
    send(3'b001, 1'b1);
    checks++; if (out_valid !== 1'b1 || syn !== 6'b001001) begin failures++; $display("FAIL gap_syn: got valid=%b syn=%b expected 1 001001", out_valid, syn); end
    checks++; if (err_flag !== 1'b1 || len_err !== 1'b0) begin failures++; $display("FAIL gap_flags: got err=%b len=%b expected 1 0", err_flag, len_err); end
    bad_hold = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sym = 3'b101; in_last = 1'b1;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || syn !== 6'b001001 || in_ready !== 1'b0 || err_flag !== 1'b1) bad_hold++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_sym = 3'b000;
    checks++; if (bad_hold !== 0) begin failures++; $display("FAIL hold_stable: got %0d unstable cycles expected 0 (syn=%b ready=%b)", bad_hold, syn, in_ready); end
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL hold_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready); end
  endtask

  task automatic test_length_errors();
    send(3'b001, 1'b0);
    send(3'b000, 1'b0);
    send(3'b000, 1'b0);
    send(3'b000, 1'b1);
    checks++; if (out_valid !== 1'b1 || syn !== 6'b101011) begin failures++; $display("FAIL short_syn: got valid=%b syn=%b expected 1 101011", out_valid, syn); end
    checks++; if (len_err !== 1'b1 || err_flag !== 1'b1) begin failures++; $display("FAIL short_flags: got len=%b err=%b expected 1 1", len_err, err_flag); end
    consume();
    send(3'b010, 1'b0);
    for (int i = 0; i < 6; i++) send(3'b000, 1'b0);
    checks++; if (out_valid !== 1'b1 || syn !== 6'b101001) begin failures++; $display("FAIL nolast_syn: got valid=%b syn=%b expected 1 101001", out_valid, syn); end
    checks++; if (len_err !== 1'b1) begin failures++; $display("FAIL nolast_len: got %b expected 1", len_err); end
    consume();
    send(3'b110, 1'b1);
    checks++; if (out_valid !== 1'b1 || syn !== 6'b110110) begin failures++; $display("FAIL single_syn: got valid=%b syn=%b expected 1 110110", out_valid, syn); end
    checks++; if (len_err !== 1'b1 || err_flag !== 1'b1) begin failures++; $display("FAIL single_flags: got len=%b err=%b expected 1 1", len_err, err_flag); end
    consume();
  endtask

  task automatic test_mid_reset();
    send(3'b101, 1'b0);
    send(3'b011, 1'b0);
    send(3'b110, 1'b0);
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || syn !== 6'b000000) begin failures++; $display("FAIL midrst_clear: got valid=%b syn=%b expected 0 000000", out_valid, syn); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send(3'b011, 1'b0);
    for (int i = 0; i < 5; i++) send(3'b000, 1'b0);
    send(3'b000, 1'b1);
    checks++; if (out_valid !== 1'b1 || syn !== 6'b010100) begin failures++; $display("FAIL midrst_syn: got valid=%b syn=%b expected 1 010100", out_valid, syn); end
    checks++; if (err_flag !== 1'b1 || len_err !== 1'b0) begin failures++; $display("FAIL midrst_flags: got err=%b len=%b expected 1 0", err_flag, len_err); end
    consume();
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_sym    = 3'b000;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_zero_codeword();
    test_generator();
    test_leading_one();
    test_gaps_and_hold();
    test_length_errors();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_engine.md
RS_SYNDROME_ENGINE -- requirements
Module: rs_syndrome_engine

Interface
REQ-001 SHALL have parameter M, default 3: symbol width in bits, GF(2^M).
REQ-002 SHALL have parameter N, default 7: codeword length in symbols, 2 <= N <= 2^M-1.
REQ-003 SHALL have parameter NSYN, default 2: number of syndromes computed, 1..N-1.
REQ-004 SHALL have parameter PRIM_POLY, default 4'b1011: primitive polynomial, x^3+x+1; alpha = x.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1: in_sym and in_last valid.
REQ-008 SHALL have port in_ready, output, 1: engine accepts a symbol this cycle.
REQ-009 SHALL have port in_sym, input, M: received symbol, polynomial basis, highest degree first.
REQ-010 SHALL have port in_last, input, 1: marks final symbol of codeword.
REQ-011 SHALL have port out_valid, output, 1: syndromes valid.
REQ-012 SHALL have port out_ready, input, 1: consumer takes syndromes.
REQ-013 SHALL have port syn, output, NSYN*M: S_j in bits [j*M-1 -: M], j=1..NSYN, polynomial basis.
REQ-014 SHALL have port err_flag, output, 1: OR of all nonzero syndromes.
REQ-015 SHALL have port len_err, output, 1: codeword length did not equal N.

Function
REQ-016 SHALL evaluate S_j = r(alpha^j) by Horner: S_j <= S_j*alpha^j XOR in_sym on each accepted symbol (in_valid & in_ready).
REQ-017 SHALL treat the first accepted symbol of a codeword as S_j <= in_sym for all j (accumulators implicitly zero).
REQ-018 SHALL implement GF add as bitwise XOR and multiply-by-alpha^j as constant reduction by PRIM_POLY; no log/antilog tables.
REQ-019 SHALL implement FSM IDLE -> ACCUM on first accepted symbol; ACCUM -> HOLD on terminating symbol; HOLD -> IDLE when out_valid & out_ready.
REQ-020 SHALL define the terminating symbol as the one with in_last=1 or the N-th accepted symbol, whichever comes first.
REQ-021 SHALL keep a symbol counter 0..N-1, cleared on entry to IDLE, never wrapping.
REQ-022 SHALL drive in_ready=1 in IDLE and ACCUM, 0 in HOLD.
REQ-023 SHALL assert out_valid the cycle after the terminating symbol is accepted (latency 1) and hold syn, err_flag, len_err stable until the handshake completes.
REQ-024 SHALL set len_err=1 if in_last arrives with count != N-1, or the N-th symbol arrives with in_last=0; syndromes still reported.
REQ-025 SHALL support N=1-symbol early termination: in_last on first symbol goes IDLE -> HOLD directly.
REQ-026 SHALL ignore in_sym and in_last when in_valid=0; cycles without a transfer leave state unchanged.
REQ-027 SHALL hold out_valid high when out_ready is low, with no limit.

Reset
REQ-028 SHALL, on reset low, asynchronously clear the FSM to IDLE, the counter, all syndrome registers, out_valid, err_flag and len_err to 0; in_ready reads 1 after release.
REQ-029 SHALL discard any partial codeword or unconsumed result on reset mid-operation.

Structure
REQ-030 SHALL place FSM state enum, PRIM_POLY default and the gf_mul_alpha_pow function in shared package rs_pkg.
REQ-031 SHALL use one sub-module, gf_const_mul (M, PRIM_POLY, POW), instantiated NSYN times via generate.

Verification (defaults M=3, N=7, NSYN=2)
REQ-032 SHALL cover: all-zero codeword, in_last on 7th -> syn S1=000, S2=000, err_flag=0, len_err=0, out_valid one cycle after 7th symbol.
REQ-033 SHALL cover: codeword 0,0,0,0,001,110,011 (generator x^2+alpha^4x+alpha^3) -> S1=000, S2=000, err_flag=0.
REQ-034 SHALL cover: 001,0,0,0,0,0,0 -> S1=101 (alpha^6), S2=111 (alpha^5), err_flag=1.
REQ-035 SHALL cover: 0,0,0,0,0,0,001 with in_valid gaps and out_ready low 5 cycles -> S1=001, S2=001, outputs stable, in_ready=0 throughout hold.
REQ-036 SHALL cover: in_last on 4th symbol -> out_valid next cycle, len_err=1; 7 symbols with in_last=0 -> len_err=1.
REQ-037 SHALL cover: reset low after 3 symbols -> out_valid=0, syn=0 immediately; next 7-symbol codeword gives correct syndromes.
